// File: rtl/qmca_dcm_lock_seq.sv
// qmca_dcm_lock_seq: power-up / re-lock sequencer for the two cascaded DCMs.
// Waits for the bus DCM lock, pulses the ADC DCM reset, then watches the ADC
// DCM lock with a per-attempt timeout and a bounded number of retries.
// Optional feature macro: QMCA_LOCK_STATS_EN (lock-loss counter on LOSS_CNT).
module qmca_dcm_lock_seq #(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 7,
  parameter int RETRY_W       = 3
) (
  input  logic               BUS_CLK,
  input  logic               BUS_RST,
  input  logic               DCM1_LOCKED,
  input  logic               DCM2_LOCKED,
  input  logic               FORCE_RELOCK,
  output logic               DCM2_RST,
  output logic               SYS_RST,
  output logic               CLK_RDY,
  output logic               ERR,
  output logic [RETRY_W-1:0] RETRY_CNT,
  output logic [7:0]         LOSS_CNT
);

  localparam logic [15:0]        HOLD_LOAD = 16'(RST_CYCLES - 1);
  localparam logic [15:0]        TO_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0]        ST_LAST   = 16'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_WAIT_L1 = 3'd0,
    S_RST2    = 3'd1,
    S_WAIT_L2 = 3'd2,
    S_STABLE  = 3'd3,
    S_RUN     = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;        // shared hold / timeout / stable counter
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               l1_meta_q, l1_s_q, l2_meta_q, l2_s_q;
  logic               fail_att;
  logic               dcm2_rst_d, clk_rdy_d, err_d;
  logic               dcm2_rst_q, sys_rst_q, clk_rdy_q, err_q;

  // Two-flop synchronisers for the asynchronous lock inputs
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      l1_meta_q <= 1'b0;
      l1_s_q    <= 1'b0;
      l2_meta_q <= 1'b0;
      l2_s_q    <= 1'b0;
    end else begin
      l1_meta_q <= DCM1_LOCKED;
      l1_s_q    <= l1_meta_q;
      l2_meta_q <= DCM2_LOCKED;
      l2_s_q    <= l2_meta_q;
    end
  end

  // State, counter and retry registers
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q <= S_WAIT_L1;
      cnt_q   <= 16'd0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic: FORCE_RELOCK beats bus-lock loss beats per-state rules
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    fail_att = 1'b0;
    if (FORCE_RELOCK) begin
      state_d = S_WAIT_L1;
      cnt_d   = 16'd0;
      retry_d = '0;
    end else if (!l1_s_q && state_q != S_WAIT_L1 && state_q != S_FAIL) begin
      state_d = S_WAIT_L1;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        S_WAIT_L1: if (l1_s_q) begin
          state_d = S_RST2;
          cnt_d   = HOLD_LOAD;
        end
        S_RST2: begin
          if (cnt_q == 16'd0) begin
            state_d = S_WAIT_L2;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_WAIT_L2: begin
          // A lock seen on the last timer cycle still counts as a lock
          if (l2_s_q) begin
            state_d = S_STABLE;
            cnt_d   = 16'd0;
          end else if (cnt_q >= TO_LAST) begin
            fail_att = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_STABLE: begin
          // A drop on the final stable cycle wins over stable-done
          if (!l2_s_q) begin
            fail_att = 1'b1;
          end else if (cnt_q >= ST_LAST) begin
            state_d = S_RUN;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_RUN: if (!l2_s_q) begin
          state_d = S_RST2;
          cnt_d   = HOLD_LOAD;
          retry_d = '0;
        end
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_WAIT_L1;
      endcase
      if (fail_att) begin
        if (retry_q == RETRY_MAX) begin
          state_d = S_FAIL;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_RST2;
          cnt_d   = HOLD_LOAD;
          retry_d = retry_q + 1'b1;
        end
      end
    end
  end

  // Output decode from the next state so outputs register alongside the state
  always_comb begin
    dcm2_rst_d = (state_d == S_WAIT_L1) || (state_d == S_RST2) || (state_d == S_FAIL);
    clk_rdy_d  = (state_d == S_RUN);
    err_d      = (state_d == S_FAIL);
  end

  // Output registers
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      dcm2_rst_q <= 1'b1;
      sys_rst_q  <= 1'b1;
      clk_rdy_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dcm2_rst_q <= dcm2_rst_d;
      sys_rst_q  <= !clk_rdy_d;
      clk_rdy_q  <= clk_rdy_d;
      err_q      <= err_d;
    end
  end

  assign DCM2_RST  = dcm2_rst_q;
  assign SYS_RST   = sys_rst_q;
  assign CLK_RDY   = clk_rdy_q;
  assign ERR       = err_q;
  assign RETRY_CNT = retry_q;

`ifdef QMCA_LOCK_STATS_EN
  logic [7:0] loss_q;
  logic       loss_evt;

  // A RUN exit caused by either lock dropping (not by FORCE_RELOCK)
  always_comb begin
    loss_evt = (state_q == S_RUN) && !FORCE_RELOCK && (!l1_s_q || !l2_s_q);
  end

  // Saturating lock-loss counter, cleared only by BUS_RST
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      loss_q <= 8'h00;
    end else if (loss_evt && loss_q != 8'hFF) begin
      loss_q <= loss_q + 8'h01;
    end
  end

  assign LOSS_CNT = loss_q;
`else
  assign LOSS_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_qmca_dcm_lock_seq.sv
// tb_qmca_dcm_lock_seq: scoreboard bench for qmca_dcm_lock_seq.
// Stimulus pushes (cycle, expected output vector) entries; a negedge monitor
// pops them at their cycle and flags any output change nobody scheduled.
module tb_qmca_dcm_lock_seq;

  logic       clk = 1'b0;
  logic       bus_rst, dcm1, dcm2, force_rl;
  logic       dcm2_rst, sys_rst, clk_rdy, err;
  logic [2:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int exp_loss = 0;
  bit mon_en  = 1'b0;

  int          q_cyc[$];
  logic [14:0] q_val[$];
  string       q_tag[$];
  logic [14:0] hold_val;
  logic [14:0] cur_val;
  logic [14:0] pop_val;
  string       pop_tag;

  qmca_dcm_lock_seq #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(100), .STABLE_CYCLES(16), .MAX_RETRY(2), .RETRY_W(3)
  ) dut (
    .BUS_CLK(clk), .BUS_RST(bus_rst), .DCM1_LOCKED(dcm1), .DCM2_LOCKED(dcm2),
    .FORCE_RELOCK(force_rl), .DCM2_RST(dcm2_rst), .SYS_RST(sys_rst), .CLK_RDY(clk_rdy),
    .ERR(err), .RETRY_CNT(retry_cnt), .LOSS_CNT(loss_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp_v);
    end else begin
      $display("ok   %s cyc=%0d val=%h", tag, cyc, obs);
    end
  endtask

  function automatic logic [14:0] mk(input logic d2, input logic sr, input logic rdy,
                                     input logic er, input logic [2:0] rt);
    return {d2, sr, rdy, er, rt, 8'(exp_loss)};
  endfunction

  task automatic push(input int c, input string t, input logic [14:0] v);
    q_cyc.push_back(c);
    q_tag.push_back(t);
    q_val.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic note_loss();
`ifdef QMCA_LOCK_STATS_EN
    exp_loss++;
`endif
  endtask

  // Monitor: scheduled checks at their cycle, any other output change is flagged
  always @(negedge clk) begin
    if (mon_en) begin
      cur_val = {dcm2_rst, sys_rst, clk_rdy, err, retry_cnt, loss_cnt};
      if (q_cyc.size() != 0 && q_cyc[0] == cyc) begin
        void'(q_cyc.pop_front());
        pop_tag = q_tag.pop_front();
        pop_val = q_val.pop_front();
        chk(pop_tag, 32'(cur_val), 32'(pop_val));
        hold_val = pop_val;
      end else if (cur_val !== hold_val) begin
        chk("unexpected_change", 32'(cur_val), 32'(hold_val));
        hold_val = cur_val;
      end
    end
  end

  initial begin
    int n, k, p, q, s, u, r;
    bus_rst = 1'b1; dcm1 = 1'b1; dcm2 = 1'b1; force_rl = 1'b0;
    step(3);
    hold_val = mk(1, 1, 0, 0, 0);
    push(cyc, "reset_vals", mk(1, 1, 0, 0, 0));
    mon_en = 1'b1;

    // Power-up with both locks high
    n = cyc; bus_rst = 1'b0;
    push(n + 7,  "pwr_dcm2rst_fall", mk(0, 1, 0, 0, 0));
    push(n + 24, "pwr_run",          mk(0, 0, 1, 0, 0));
    step(30);

    // Bus DCM lock lost in RUN, then restored
    n = cyc; dcm1 = 1'b0; note_loss();
    push(n + 3, "l1_loss_run", mk(1, 1, 0, 0, 0));
    step(10);
    n = cyc; dcm1 = 1'b1;
    push(n + 7,  "l1_relock_dcm2rst", mk(0, 1, 0, 0, 0));
    push(n + 24, "l1_relock_run",     mk(0, 0, 1, 0, 0));
    step(30);

    // FORCE_RELOCK from RUN, then a 1-cycle DCM2 glitch during STABLE
    n = cyc; force_rl = 1'b1;
    push(n + 1, "force_from_run",  mk(1, 1, 0, 0, 0));
    push(n + 6, "force_dcm2rst",   mk(0, 1, 0, 0, 0));
    step(1); force_rl = 1'b0;
    step(9);
    k = cyc; dcm2 = 1'b0;
    push(k + 3,  "glitch_retry1", mk(1, 1, 0, 0, 1));
    push(k + 7,  "glitch_dcm2rst", mk(0, 1, 0, 0, 1));
    push(k + 24, "glitch_run",     mk(0, 0, 1, 0, 1));
    step(1); dcm2 = 1'b1;
    step(30);

    // DCM2 loss in RUN clears retries; FORCE_RELOCK beats l2_s rising in WAIT_L2
    p = cyc; dcm2 = 1'b0; note_loss();
    push(p + 3, "l2_loss_run",   mk(1, 1, 0, 0, 0));
    push(p + 7, "l2_loss_wait2", mk(0, 1, 0, 0, 0));
    step(10);
    q = cyc; dcm2 = 1'b1;
    push(q + 3,  "force_beats_l2", mk(1, 1, 0, 0, 0));
    push(q + 8,  "prio_dcm2rst",   mk(0, 1, 0, 0, 0));
    push(q + 25, "prio_run",       mk(0, 0, 1, 0, 0));
    step(2); force_rl = 1'b1;
    step(1); force_rl = 1'b0;
    step(30);

    // DCM2 never locks: three timed-out attempts, then FAIL
    s = cyc; dcm2 = 1'b0; note_loss();
    push(s + 3,   "to_rst2",        mk(1, 1, 0, 0, 0));
    push(s + 7,   "to_wait2_a0",    mk(0, 1, 0, 0, 0));
    push(s + 107, "timeout_retry1", mk(1, 1, 0, 0, 1));
    push(s + 111, "to_wait2_a1",    mk(0, 1, 0, 0, 1));
    push(s + 211, "timeout_retry2", mk(1, 1, 0, 0, 2));
    push(s + 215, "to_wait2_a2",    mk(0, 1, 0, 0, 2));
    push(s + 315, "timeout_fail",   mk(1, 1, 0, 1, 2));
    step(320);
    // FAIL is sticky: DCM2 relock and a bus-lock blip change nothing
    dcm2 = 1'b1; step(5);
    dcm1 = 1'b0; step(5);
    dcm1 = 1'b1; step(10);

    // Recovery from FAIL via FORCE_RELOCK
    u = cyc; force_rl = 1'b1;
    push(u + 1,  "recover_clear",   mk(1, 1, 0, 0, 0));
    push(u + 6,  "recover_dcm2rst", mk(0, 1, 0, 0, 0));
    push(u + 23, "recover_run",     mk(0, 0, 1, 0, 0));
    step(1); force_rl = 1'b0;
    step(29);

    // BUS_RST in the middle of RST2, then a clean restart
    r = cyc; force_rl = 1'b1;
    push(r + 1, "pre_rst_force", mk(1, 1, 0, 0, 0));
    step(1); force_rl = 1'b0;
    step(2); bus_rst = 1'b1; exp_loss = 0;
    push(r + 4, "busrst_mid_rst2", mk(1, 1, 0, 0, 0));
    step(3);
    n = cyc; bus_rst = 1'b0;
    push(n + 7,  "rst_again_dcm2rst", mk(0, 1, 0, 0, 0));
    push(n + 24, "rst_again_run",     mk(0, 0, 1, 0, 0));
    step(30);

    chk("scoreboard_drained", 32'(q_cyc.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
